// File: rtl/timer_dev_pkg.sv
// Shared definitions for the memory-mapped countdown timer: register offsets,
// FSM state encoding, CTRL field positions and mode codes.
package timer_dev_pkg;

  localparam logic [1:0] TMR_CTRL   = 2'd0;
  localparam logic [1:0] TMR_PRESET = 2'd1;
  localparam logic [1:0] TMR_COUNT  = 2'd2;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_LOAD = 2'd1,
    S_CNT  = 2'd2,
    S_INT  = 2'd3
  } state_e;

  localparam logic [1:0] MODE_ONESHOT = 2'b00;
  localparam logic [1:0] MODE_RELOAD  = 2'b01;

  localparam int CTRL_EN      = 0;
  localparam int CTRL_MODE_LO = 1;
  localparam int CTRL_MODE_HI = 2;
  localparam int CTRL_IM      = 3;

endpackage

// File: rtl/timer_dev_byte_merge.sv
// Per-byte write merge: each enabled byte lane of wdata replaces the
// corresponding byte of the current register value.
module timer_dev_byte_merge (
  input  logic [31:0] cur_i,
  input  logic [3:0]  byteen_i,
  input  logic [31:0] wdata_i,
  output logic [31:0] merged_o
);

  always_comb begin
    merged_o = cur_i;
    for (int i = 0; i < 4; i++) begin
      if (byteen_i[i]) merged_o[8*i +: 8] = wdata_i[8*i +: 8];
    end
  end

endmodule

// File: rtl/timer_dev.sv
// Countdown timer on the data bus: CTRL/PRESET byte-writable, COUNT read-only,
// one-shot or auto-reload operation, masked interrupt request.
module timer_dev
  import timer_dev_pkg::*;
#(
  parameter int COUNT_W = 32,
  parameter int CTRL_W  = 4
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        sel,
  input  logic [1:0]  addr,
  input  logic [3:0]  byteen,
  input  logic [31:0] wdata,
  output logic [31:0] rdata,
  output logic        irq,
  output logic [1:0]  dbg_state
);

  // Bus handshake: a write is accepted in any cycle with sel=1 and at least one
  // byte enable set; there is no back-pressure and reads never stall.
  logic [CTRL_W-1:0]  ctrl_q, ctrl_d;
  logic [COUNT_W-1:0] preset_q, preset_d;
  logic [COUNT_W-1:0] count_q, count_d;
  logic               flag_q, flag_d;
  state_e             state_q, state_d;

  logic               wr, ctrl_wr, preset_wr, clr_en;
  logic [31:0]        ctrl_ext, preset_ext, count_ext;
  logic [31:0]        ctrl_merged, preset_merged;
  logic               unused_merge_bits;

  assign wr        = sel & (|byteen);
  assign ctrl_wr   = wr && (addr == TMR_CTRL);
  assign preset_wr = wr && (addr == TMR_PRESET);

  always_comb begin
    ctrl_ext   = '0;
    preset_ext = '0;
    count_ext  = '0;
    ctrl_ext[CTRL_W-1:0]    = ctrl_q;
    preset_ext[COUNT_W-1:0] = preset_q;
    count_ext[COUNT_W-1:0]  = count_q;
  end

  timer_dev_byte_merge u_ctrl_merge (
    .cur_i    (ctrl_ext),
    .byteen_i (byteen),
    .wdata_i  (wdata),
    .merged_o (ctrl_merged)
  );

  timer_dev_byte_merge u_preset_merge (
    .cur_i    (preset_ext),
    .byteen_i (byteen),
    .wdata_i  (wdata),
    .merged_o (preset_merged)
  );

  // Bits above the implemented register widths are dropped on purpose.
  assign unused_merge_bits = ^{ctrl_merged, preset_merged};

  // A bus write to CTRL takes priority over the FSM clearing EN.
  always_comb begin
    ctrl_d = ctrl_q;
    if (clr_en) ctrl_d[CTRL_EN] = 1'b0;
    if (ctrl_wr) ctrl_d = ctrl_merged[CTRL_W-1:0];
    preset_d = preset_wr ? preset_merged[COUNT_W-1:0] : preset_q;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      ctrl_q   <= '0;
      preset_q <= '0;
    end else begin
      ctrl_q   <= ctrl_d;
      preset_q <= preset_d;
    end
  end

  always_comb begin
    state_d = state_q;
    count_d = count_q;
    flag_d  = flag_q;
    clr_en  = 1'b0;
    if (ctrl_wr || preset_wr) flag_d = 1'b0;
    case (state_q)
      S_IDLE: if (ctrl_q[CTRL_EN]) state_d = S_LOAD;
      S_LOAD: begin
        count_d = preset_q;
        state_d = S_CNT;
      end
      S_CNT: begin
        if (!ctrl_q[CTRL_EN]) begin
          state_d = S_IDLE;
        end else if (count_q > COUNT_W'(1)) begin
          count_d = count_q - COUNT_W'(1);
        end else begin
          count_d = '0;
          flag_d  = 1'b1;
          state_d = S_INT;
        end
      end
      S_INT: begin
        state_d = S_IDLE;
        // Reserved mode codes 1x behave as one-shot.
        case (ctrl_q[CTRL_MODE_HI:CTRL_MODE_LO])
          MODE_RELOAD:  flag_d = 1'b0;
          MODE_ONESHOT: clr_en = 1'b1;
          default:      clr_en = 1'b1;
        endcase
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= S_IDLE;
      count_q <= '0;
      flag_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      count_q <= count_d;
      flag_q  <= flag_d;
    end
  end

  always_comb begin
    case (addr)
      TMR_CTRL:   rdata = ctrl_ext;
      TMR_PRESET: rdata = preset_ext;
      TMR_COUNT:  rdata = count_ext;
      default:    rdata = '0;
    endcase
  end

  assign irq       = ctrl_q[CTRL_IM] & flag_q;
  assign dbg_state = state_q;

endmodule
